project_wb_ctrl: RTL and testbench
==================================

Name: project_wb_ctrl

Overview:
- Wishbone slave register block sitting directly upstream of the per-project slots in the multi-project harness.
- Decodes management-SoC Wishbone accesses, latches the active-project selection, and drives each project's update strobe, data word and active-high reset.
- Replaces ad-hoc strobe decode with a single registered, acknowledged interface.
- Single clock domain (clk = wb_clk_i at the wrapper).

Parameters:
- NUM_PROJECTS, 8, number of project slots; 1..8.
- ADDR_BASE, 32'h3000_0000, slave base address; bits [31:8] are compared.
- RST_CNT_W, 16, width of the soft-reset hold counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- proj_data  out  32  latched DATA word, shared by all projects.
- proj_wb_update  out  NUM_PROJECTS  one-cycle update strobe per project.
- proj_reset  out  NUM_PROJECTS  active-high reset per project.
- active_project  out  3  current CTRL.sel field.

Behaviour:
- Reset (reset_n low at posedge) forces the following values:
  - wbs_ack_o=0, wbs_dat_o=0, proj_data=0, proj_wb_update=0.
  - proj_reset = all ones.
  - CTRL=0, reset counter=0, write count=0, active_project=0.
  - An in-flight access is dropped. The master must retry.
- Decode:
  - hit = cyc & stb & (adr[31:8]==ADDR_BASE[31:8]). Offset = adr[7:2].
  - Non-hit accesses are never acked.
- Handshake:
  - A hit is sampled only when wbs_ack_o=0.
  - wbs_ack_o goes high the next cycle for exactly one cycle. Latency is 1.
  - Back-to-back hits therefore ack every other cycle.
  - Writes take effect on the same edge that raises ack. wbs_dat_o is valid in the ack cycle and is 0 otherwise.
- Registers. Byte enables apply per byte on writes.
  - 0x00 CTRL, RW:
    - [2:0] sel, [8] en, other bits read 0.
    - Any write to CTRL clears the reset counter.
  - 0x04 DATA, W. Reads return proj_data.
    - A write merges bytes into proj_data.
    - If en=1 and sel<NUM_PROJECTS, proj_wb_update[sel] pulses high in the ack cycle only. proj_data already holds the new value in that cycle.
    - Otherwise no pulse is generated, but proj_data still updates.
  - 0x08 RSTCNT, W:
    - Loads the counter with dat[RST_CNT_W-1:0]; sel is ignored.
    - The counter decrements by 1 per cycle to 0 and does not wrap.
    - Reads return the remaining count.
    - Writing 0 produces no reset pulse.
  - 0x0C STATUS, RO:
    - [15:0] DATA write count: increments on every DATA write, saturates at 16'hFFFF, does not wrap.
    - [16] busy, defined as counter != 0.
    - Writes are acked and ignored.
  - Any other offset: acked; reads return 0; writes are ignored.
- Project reset. proj_reset is registered and changes one cycle after the cause.
  - proj_reset[i] = !en | (sel != i) | (counter != 0).
  - Unselected projects are held in reset.
  - sel >= NUM_PROJECTS puts all projects in reset.
- Simultaneous events:
  - A CTRL write that changes sel while the counter is running clears the counter. The new project leaves reset after the one-cycle register delay.
  - A RSTCNT write while the counter is nonzero reloads the counter.
  - A DATA write during a soft reset still pulses proj_wb_update.
- active_project mirrors CTRL.sel.

Decomposition:
- Package project_wb_ctrl_pkg holds:
  - Register offsets (OFS_CTRL/DATA/RSTCNT/STATUS).
  - CTRL field positions (SEL_LSB/MSB, EN_BIT).
  - STATUS field positions (WCNT_MSB, BUSY_BIT).
- One sub-module, project_reset_timer, contains the loadable down-counter.
  - Inputs: load, load_val, clear.
  - Outputs: busy, count.

Test Plan:
- Reset, then idle 5 cycles -> proj_reset=8'hFF, ack never seen, all outputs 0.
- Write CTRL=0x102, then DATA=0xDEADBEEF with sel=4'hF:
  - Ack exactly 1 cycle after stb.
  - proj_wb_update=8'h04 for one cycle, proj_data=0xDEADBEEF.
  - proj_reset=8'hFB after the CTRL write.
  - STATUS reads 0x0000_0001.
- DATA write with sel=4'b0001, data 0x11223344, over 0xDEADBEEF -> proj_data=0xDEADBE44.
- With CTRL=0x102, write RSTCNT=3:
  - proj_reset[2] high for 3 cycles, then low.
  - STATUS busy reads 1 mid-pulse.
  - A CTRL write to 0x105 mid-count clears busy and gives proj_reset=8'hDF.
- CTRL=0x007 with NUM_PROJECTS=4, then DATA write -> no update pulse, proj_reset=4'hF.
- Read at offset 0x20 -> ack with 0. Address 0x3000_0100 -> no ack. reset_n low during stb -> ack suppressed.

Source files
------------

// File: rtl/project_wb_ctrl_pkg.sv
// Shared definitions for the multi-project Wishbone control block:
// register word offsets, register field positions and a byte-lane merge helper.
package project_wb_ctrl_pkg;

  // Word offsets (wbs_adr_i[7:2]) of the architected registers
  localparam logic [5:0] OFS_CTRL   = 6'h00;
  localparam logic [5:0] OFS_DATA   = 6'h01;
  localparam logic [5:0] OFS_RSTCNT = 6'h02;
  localparam logic [5:0] OFS_STATUS = 6'h03;

  // CTRL field positions
  localparam int SEL_LSB = 0;
  localparam int SEL_MSB = 2;
  localparam int SEL_W   = SEL_MSB - SEL_LSB + 1;
  localparam int EN_BIT  = 8;

  // STATUS field positions
  localparam int WCNT_MSB = 15;
  localparam int WCNT_W   = WCNT_MSB + 1;
  localparam int BUSY_BIT = 16;

  // Replace only the byte lanes whose enable is set, keep the others
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/project_wb_ctrl_timer.sv
// Soft-reset hold counter: loadable down-counter that stops at zero.
// While the count is nonzero the selected project is held in reset.
module project_reset_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clear_i,
  output logic         busy_o,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Clear wins over load; otherwise count down by one and hold at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign busy_o  = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/project_wb_ctrl.sv
// Wishbone slave register block in front of the multi-project slots.
// Holds the project selection, the shared data word and the soft-reset
// timer, and drives per-project update strobes and resets.
module project_wb_ctrl
  import project_wb_ctrl_pkg::*;
#(
  parameter int          NUM_PROJECTS = 8,
  parameter logic [31:0] ADDR_BASE    = 32'h3000_0000,
  parameter int          RST_CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [31:0]             proj_data,
  output logic [NUM_PROJECTS-1:0] proj_wb_update,
  output logic [NUM_PROJECTS-1:0] proj_reset,
  output logic [2:0]              active_project
);

  logic                    ack_q;
  logic [31:0]             dat_q;
  logic [31:0]             data_q;
  logic [SEL_W-1:0]        sel_q;
  logic                    en_q;
  logic [WCNT_W-1:0]       wcnt_q;
  logic [NUM_PROJECTS-1:0] upd_q;
  logic [NUM_PROJECTS-1:0] upd_d;
  logic [NUM_PROJECTS-1:0] rst_q;
  logic [NUM_PROJECTS-1:0] rst_d;

  logic                    hit;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [5:0]              ofs;
  logic                    sel_ok;
  logic [SEL_W-1:0]        sel_new;
  logic                    en_new;
  logic [31:0]             rd_data;
  logic [31:0]             rst_merge;
  logic                    tmr_busy;
  logic [RST_CNT_W-1:0]    tmr_count;
  logic                    tmr_load;
  logic                    tmr_clear;
  logic                    unused_ok;

  // A hit is only taken while no ack is outstanding, so each access acks once
  assign hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign accept = hit && !ack_q;
  assign wr_acc = accept && wbs_we_i;
  assign rd_acc = accept && !wbs_we_i;
  assign ofs    = wbs_adr_i[7:2];

  // Only lane 0 carries sel and lane 1 carries en
  assign sel_new = wbs_sel_i[0] ? wbs_dat_i[SEL_MSB:SEL_LSB] : sel_q;
  assign en_new  = wbs_sel_i[1] ? wbs_dat_i[EN_BIT] : en_q;
  assign sel_ok  = en_q && (32'(sel_q) < 32'(NUM_PROJECTS));

  assign rst_merge = merge_bytes(32'(tmr_count), wbs_dat_i, wbs_sel_i);
  assign tmr_load  = wr_acc && (ofs == OFS_RSTCNT);
  assign tmr_clear = wr_acc && (ofs == OFS_CTRL);

  assign unused_ok = &{1'b0, wbs_adr_i[1:0], rst_merge};

  project_reset_timer #(
    .W (RST_CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (rst_merge[RST_CNT_W-1:0]),
    .clear_i    (tmr_clear),
    .busy_o     (tmr_busy),
    .count_o    (tmr_count)
  );

  // Read mux over current register state; unmapped offsets read as zero
  always_comb begin
    rd_data = '0;
    case (ofs)
      OFS_CTRL: begin
        rd_data[SEL_MSB:SEL_LSB] = sel_q;
        rd_data[EN_BIT]          = en_q;
      end
      OFS_DATA:   rd_data = data_q;
      OFS_RSTCNT: rd_data = 32'(tmr_count);
      OFS_STATUS: begin
        rd_data[WCNT_MSB:0] = wcnt_q;
        rd_data[BUSY_BIT]   = tmr_busy;
      end
      default:    rd_data = '0;
    endcase
  end

  // Next-state of the per-project strobes and resets from current CTRL/timer
  always_comb begin
    upd_d = '0;
    rst_d = '1;
    for (int i = 0; i < NUM_PROJECTS; i++) begin
      upd_d[i] = wr_acc && (ofs == OFS_DATA) && sel_ok && (sel_q == i[SEL_W-1:0]);
      rst_d[i] = !en_q || (sel_q != i[SEL_W-1:0]) || tmr_busy;
    end
  end

  // Handshake and output registers: ack and read data live for one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      upd_q <= '0;
      rst_q <= '1;
    end else begin
      ack_q <= accept;
      dat_q <= rd_acc ? rd_data : 32'h0;
      upd_q <= upd_d;
      rst_q <= rst_d;
    end
  end

  // Writable register state: CTRL fields, DATA word and saturating write count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q  <= '0;
      en_q   <= 1'b0;
      data_q <= '0;
      wcnt_q <= '0;
    end else begin
      if (wr_acc && (ofs == OFS_CTRL)) begin
        sel_q <= sel_new;
        en_q  <= en_new;
      end
      if (wr_acc && (ofs == OFS_DATA)) begin
        data_q <= merge_bytes(data_q, wbs_dat_i, wbs_sel_i);
        if (wcnt_q != '1) wcnt_q <= wcnt_q + WCNT_W'(1);
      end
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign proj_data      = data_q;
  assign proj_wb_update = upd_q;
  assign proj_reset     = rst_q;
  assign active_project = sel_q;

endmodule

// File: tb/tb_project_wb_ctrl.sv
// Directed bench for project_wb_ctrl. Two instances share one Wishbone bus:
// an 8-slot block and a 4-slot block, so out-of-range selections can be seen.
module tb_project_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;

  logic        ack8, ack4;
  logic [31:0] dat8, dat4, pdata8, pdata4;
  logic [7:0]  upd8, rst8;
  logic [3:0]  upd4, rst4;
  logic [2:0]  act8, act4;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] ackData;
  logic [7:0]  ackUpd8;
  logic [3:0]  ackUpd4;
  int          ackLat;

  localparam logic [31:0] BASE = 32'h3000_0000;

  always #5 clk = ~clk;

  project_wb_ctrl #(.NUM_PROJECTS(8), .ADDR_BASE(BASE), .RST_CNT_W(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_o(ack8), .wbs_dat_o(dat8), .proj_data(pdata8),
    .proj_wb_update(upd8), .proj_reset(rst8), .active_project(act8)
  );

  project_wb_ctrl #(.NUM_PROJECTS(4), .ADDR_BASE(BASE), .RST_CNT_W(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_o(ack4), .wbs_dat_o(dat4), .proj_data(pdata4),
    .proj_wb_update(upd4), .proj_reset(rst4), .active_project(act4)
  );

  // Single comparison point: counts the check and reports on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Step n clock cycles, leaving time 1 ns after the last rising edge
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One Wishbone access; records ack latency (0 = no ack within maxCycles),
  // the ack-cycle read data and update strobes, then idles one cycle
  task automatic applyStimulus(input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] be,
                               input int maxCycles);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = be;
    ackLat    = 0;
    ackData   = '0;
    ackUpd8   = '0;
    ackUpd4   = '0;
    for (int c = 1; c <= maxCycles; c++) begin
      @(posedge clk);
      #1;
      if (ack8) begin
        ackLat  = c;
        ackData = dat8;
        ackUpd8 = upd8;
        ackUpd4 = upd4;
        break;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    waitCycles(1);
  endtask

  // Safety net in case the design never lets the sequence advance
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations
  initial begin
    reset_n   = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    waitCycles(3);

    checkOutput("rst_proj_reset8", 32'(rst8), 32'hFF);
    checkOutput("rst_proj_reset4", 32'(rst4), 32'hF);
    checkOutput("rst_ack", 32'(ack8), 32'h0);
    checkOutput("rst_dat", dat8, 32'h0);
    checkOutput("rst_proj_data", pdata8, 32'h0);
    checkOutput("rst_update", 32'(upd8), 32'h0);
    checkOutput("rst_active", 32'(act8), 32'h0);

    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitCycles(1);
      checkOutput("idle_ack", 32'(ack8), 32'h0);
      checkOutput("idle_proj_reset", 32'(rst8), 32'hFF);
    end

    // Select project 2 and enable
    applyStimulus(1'b1, BASE + 32'h00, 32'h0000_0102, 4'hF, 4);
    checkOutput("ctrl_lat", 32'(ackLat), 32'd1);
    checkOutput("ctrl_active", 32'(act8), 32'd2);
    checkOutput("ctrl_proj_reset8", 32'(rst8), 32'hFB);
    checkOutput("ctrl_proj_reset4", 32'(rst4), 32'hB);

    applyStimulus(1'b1, BASE + 32'h04, 32'hDEAD_BEEF, 4'hF, 4);
    checkOutput("data_lat", 32'(ackLat), 32'd1);
    checkOutput("data_upd8", 32'(ackUpd8), 32'h04);
    checkOutput("data_upd4", 32'(ackUpd4), 32'h4);
    checkOutput("data_proj_data", pdata8, 32'hDEAD_BEEF);
    checkOutput("data_upd_after", 32'(upd8), 32'h0);

    applyStimulus(1'b0, BASE + 32'h0C, 32'h0, 4'hF, 4);
    checkOutput("status_1", ackData, 32'h0000_0001);

    // Partial byte write merges lane 0 only
    applyStimulus(1'b1, BASE + 32'h04, 32'h1122_3344, 4'b0001, 4);
    checkOutput("merge_proj_data", pdata8, 32'hDEAD_BE44);
    checkOutput("merge_upd8", 32'(ackUpd8), 32'h04);
    applyStimulus(1'b0, BASE + 32'h04, 32'h0, 4'hF, 4);
    checkOutput("data_read", ackData, 32'hDEAD_BE44);

    // Three-cycle soft reset on project 2
    applyStimulus(1'b1, BASE + 32'h08, 32'd3, 4'hF, 4);
    checkOutput("soft_rst_c1", 32'(rst8), 32'hFF);
    waitCycles(1);
    checkOutput("soft_rst_c2", 32'(rst8), 32'hFF);
    waitCycles(1);
    checkOutput("soft_rst_c3", 32'(rst8), 32'hFF);
    waitCycles(1);
    checkOutput("soft_rst_end", 32'(rst8), 32'hFB);

    // Long soft reset: busy visible, counter decrementing, then CTRL clears it
    applyStimulus(1'b1, BASE + 32'h08, 32'd100, 4'hF, 4);
    applyStimulus(1'b0, BASE + 32'h0C, 32'h0, 4'hF, 4);
    checkOutput("status_busy", ackData, 32'h0001_0002);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 4'hF, 4);
    checkOutput("rstcnt_read", ackData, 32'd97);
    applyStimulus(1'b1, BASE + 32'h00, 32'h0000_0105, 4'hF, 4);
    checkOutput("ctrl_clear_reset", 32'(rst8), 32'hDF);
    checkOutput("ctrl_clear_reset4", 32'(rst4), 32'hF);
    applyStimulus(1'b0, BASE + 32'h0C, 32'h0, 4'hF, 4);
    checkOutput("status_not_busy", ackData, 32'h0000_0002);

    // Loading zero gives no reset pulse
    applyStimulus(1'b1, BASE + 32'h08, 32'd0, 4'hF, 4);
    checkOutput("zero_load_a", 32'(rst8), 32'hDF);
    waitCycles(2);
    checkOutput("zero_load_b", 32'(rst8), 32'hDF);

    // DATA write during soft reset still strobes project 5
    applyStimulus(1'b1, BASE + 32'h08, 32'd50, 4'hF, 4);
    applyStimulus(1'b1, BASE + 32'h04, 32'hCAFE_F00D, 4'hF, 4);
    checkOutput("busy_data_upd8", 32'(ackUpd8), 32'h20);
    checkOutput("busy_data_upd4", 32'(ackUpd4), 32'h0);
    checkOutput("busy_proj_reset", 32'(rst8), 32'hFF);
    checkOutput("busy_proj_data", pdata8, 32'hCAFE_F00D);

    // sel=7: valid for the 8-slot block, out of range for the 4-slot block
    applyStimulus(1'b1, BASE + 32'h00, 32'h0000_0107, 4'hF, 4);
    checkOutput("sel7_reset8", 32'(rst8), 32'h7F);
    checkOutput("sel7_reset4", 32'(rst4), 32'hF);
    checkOutput("sel7_active4", 32'(act4), 32'd7);
    applyStimulus(1'b1, BASE + 32'h04, 32'h0000_0055, 4'hF, 4);
    checkOutput("sel7_upd8", 32'(ackUpd8), 32'h80);
    checkOutput("sel7_upd4", 32'(ackUpd4), 32'h0);
    checkOutput("sel7_data4", pdata4, 32'h0000_0055);

    // en=0 with sel=7: no strobe, everything in reset
    applyStimulus(1'b1, BASE + 32'h00, 32'h0000_0007, 4'hF, 4);
    checkOutput("dis_reset8", 32'(rst8), 32'hFF);
    applyStimulus(1'b1, BASE + 32'h04, 32'h0000_0066, 4'hF, 4);
    checkOutput("dis_upd8", 32'(ackUpd8), 32'h0);
    checkOutput("dis_data8", pdata8, 32'h0000_0066);
    applyStimulus(1'b0, BASE + 32'h0C, 32'h0, 4'hF, 4);
    checkOutput("status_wcnt", ackData, 32'h0000_0005);

    // Unmapped offset acks with zero; foreign address never acks
    applyStimulus(1'b0, BASE + 32'h20, 32'h0, 4'hF, 4);
    checkOutput("unmapped_lat", 32'(ackLat), 32'd1);
    checkOutput("unmapped_data", ackData, 32'h0);
    applyStimulus(1'b0, 32'h3000_0100, 32'h0, 4'hF, 4);
    checkOutput("foreign_noack", 32'(ackLat), 32'd0);

    // Held strobe acks every other cycle
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = BASE;
    wbs_sel_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      waitCycles(1);
      checkOutput("b2b_ack", 32'(ack8), (k % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput("b2b_dat", dat8, (k % 2 == 0) ? 32'h0000_0007 : 32'h0);
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    waitCycles(1);

    // Reset asserted while a write is presented: dropped, no ack
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = BASE;
    wbs_dat_i = 32'h0000_0103;
    reset_n   = 1'b0;
    waitCycles(1);
    checkOutput("rst_stb_ack", 32'(ack8), 32'h0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    waitCycles(1);
    reset_n = 1'b1;
    waitCycles(1);
    checkOutput("rst2_proj_reset", 32'(rst8), 32'hFF);
    checkOutput("rst2_active", 32'(act8), 32'h0);
    checkOutput("rst2_proj_data", pdata8, 32'h0);
    applyStimulus(1'b0, BASE + 32'h00, 32'h0, 4'hF, 4);
    checkOutput("rst2_ctrl", ackData, 32'h0);
    applyStimulus(1'b0, BASE + 32'h0C, 32'h0, 4'hF, 4);
    checkOutput("rst2_status", ackData, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
